count_display_driver: RTL and testbench

COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

---
 rtl/count_display_driver.sv | 150 +++++++++++++++
 tb/tb_count_display_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/count_display_driver.sv
// ---------------------------------------------------------------------------
// | count_display_driver                                                    |
// | 4-bit count -> BCD (serial double-dabble) -> 2-digit muxed 7-seg driver |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module count_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [7:0] bcd,
  output logic       busy
);

  localparam int             c_pw        = $clog2(REFRESH_DIV);
  localparam logic [c_pw-1:0] c_presc_max = c_pw'(REFRESH_DIV - 1);
  localparam logic [0:0]     c_idle      = 1'b0;
  localparam logic [0:0]     c_conv      = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [3:0]      r_last_val;
  logic [3:0]      r_cap;
  logic [3:0]      r_shift;
  logic [7:0]      r_scratch;
  logic [1:0]      r_step;
  logic [7:0]      w_adj;
  logic [11:0]     w_shift;
  logic            w_start;
  logic [c_pw-1:0] r_presc;
  logic            r_digit_sel;
  logic [6:0]      w_seg_next;
  logic [1:0]      w_an_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign w_start = (r_state == c_idle) && (count != r_last_val);

  // Converter FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_next;
  end

  // Converter FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (w_start) w_state_next = c_conv;
      c_conv:  if (r_step == 2'd3) w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  // Converter FSM: outputs
  always_comb begin
    busy = (r_state == c_conv);
  end

  // One double-dabble step: add-3 correction, then shift the joined register
  always_comb begin
    w_adj[3:0] = (r_scratch[3:0] >= 4'd5) ? r_scratch[3:0] + 4'd3 : r_scratch[3:0];
    w_adj[7:4] = (r_scratch[7:4] >= 4'd5) ? r_scratch[7:4] + 4'd3 : r_scratch[7:4];
    w_shift    = {w_adj[6:0], r_shift, 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_val <= 4'd0;
      r_cap      <= 4'd0;
      r_shift    <= 4'd0;
      r_scratch  <= 8'd0;
      r_step     <= 2'd0;
      bcd        <= 8'h00;
    end else if (w_start) begin
      r_cap     <= count;
      r_shift   <= count;
      r_scratch <= 8'd0;
      r_step    <= 2'd0;
    end else if (r_state == c_conv) begin
      r_scratch <= w_shift[11:4];
      r_shift   <= w_shift[3:0];
      r_step    <= r_step + 2'd1;
      if (r_step == 2'd3) begin
        bcd        <= w_shift[11:4];
        r_last_val <= r_cap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_digit_sel <= 1'b0;
    end else if (r_presc == c_presc_max) begin
      r_presc     <= '0;
      r_digit_sel <= ~r_digit_sel;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Tens slot stays dark when the tens digit is zero
  always_comb begin
    w_an_next  = 2'b11;
    w_seg_next = 7'h7F;
    if (!blank) begin
      if (!r_digit_sel) begin
        w_an_next  = 2'b10;
        w_seg_next = decode(bcd[3:0]);
      end else begin
        w_an_next  = (bcd[7:4] == 4'd0) ? 2'b11 : 2'b01;
        w_seg_next = decode(bcd[7:4]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 2'b11;
      seg <= 7'h7F;
    end else begin
      an  <= w_an_next;
      seg <= w_seg_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_count_display_driver.sv
// ---------------------------------------------------------------------------
// | tb_count_display_driver                                                 |
// | Scoreboard bench: conversions queued at stimulus, checked on busy fall  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_count_display_driver;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] count = 4'd0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [7:0] bcd;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_q[$];
  logic [6:0] segtab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  count_display_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .count(count), .blank(blank),
    .seg(seg), .an(an), .bcd(bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a falling busy presents a finished conversion
  logic       prev_busy = 1'b0;
  logic [7:0] prev_bcd  = 8'h00;
  logic [7:0] mon_exp;
  int         busy_len  = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      prev_bcd  = bcd;
      busy_len  = 0;
    end else begin
      if (busy) busy_len++;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL conv_unexpected: got bcd %0h expected no conversion", bcd);
        end else begin
          mon_exp = exp_q.pop_front();
          check("conv_bcd", bcd, mon_exp);
        end
        check("busy_len", busy_len, 4);
        busy_len = 0;
      end else if (bcd !== prev_bcd) begin
        compared++;
        mismatched++;
        $display("FAIL bcd_glitch: got %0h expected %0h held", bcd, prev_bcd);
      end
      prev_busy = busy;
      prev_bcd  = bcd;
    end
  end

  task automatic drive(input logic [3:0] v);
    @(posedge clk);
    #1 count = v;
    exp_q.push_back({(v >= 4'd10) ? 4'd1 : 4'd0, (v >= 4'd10) ? v - 4'd10 : v});
  endtask

  task automatic wait_idle();
    int n;
    repeat (2) @(negedge clk);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle: got busy=1 expected 0 within 20 cycles");
    end
  endtask

  // Watch one full refresh period and look for both digit slots
  task automatic check_slots(input string name, input logic [3:0] v);
    logic [6:0] ones_seg;
    logic [1:0] tens_an;
    logic       saw_ones, saw_tens, bad, saw_busy;
    ones_seg = segtab[v % 10];
    tens_an  = (v >= 4'd10) ? 2'b01 : 2'b11;
    saw_ones = 1'b0; saw_tens = 1'b0; bad = 1'b0; saw_busy = 1'b0;
    @(negedge clk);
    repeat (8) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (an == 2'b10 && seg == ones_seg) saw_ones = 1'b1;
      else if (an == tens_an && (tens_an == 2'b11 || seg == 7'b1111001)) saw_tens = 1'b1;
      else bad = 1'b1;
    end
    check({name, "_ones"}, saw_ones, 1);
    check({name, "_tens"}, saw_tens, 1);
    check({name, "_other"}, bad, 0);
    check({name, "_busy"}, saw_busy, 0);
  endtask

  initial begin
    logic ok;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_bcd", bcd, 8'h00);
    check("rst_an", an, 2'b11);
    check("rst_seg", seg, 7'h7F);
    rst = 1'b0;
    @(negedge clk);
    check("first_an", an, 2'b10);
    check("first_seg", seg, 7'b1000000);
    check_slots("zero", 4'd0);

    drive(4'd13);
    wait_idle();
    check_slots("thirteen", 4'd13);

    drive(4'd9);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 count = 4'd12;
    exp_q.push_back(8'h12);
    wait_idle();
    wait_idle();
    check_slots("twelve", 4'd12);

    @(posedge clk);
    #1 blank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("blank_an", an, 2'b11);
    check("blank_seg", seg, 7'h7F);
    repeat (5) @(negedge clk);
    check("blank_hold_an", an, 2'b11);
    @(posedge clk);
    #1 blank = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ok = (an == 2'b10 && seg == 7'b0100100) || (an == 2'b01 && seg == 7'b1111001);
    check("blank_resume", ok, 1);

    @(posedge clk);
    #1 count = 4'd5;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd, 8'h00);
    check("abort_an", an, 2'b11);
    check("abort_seg", seg, 7'h7F);
    @(negedge clk);
    count = 4'd7;
    exp_q.push_back(8'h07);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    check_slots("seven", 4'd7);

    for (int v = 0; v < 16; v++) begin
      drive(4'(v));
      wait_idle();
      check_slots("sweep", 4'(v));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
